// File: rtl/sdram_access_arbiter_if.sv
// Handshake bundle between the SDRAM access arbiter, the display line-tag side,
// the single-word user port and the SDRAM controller call/done pins.
interface sdram_access_arbiter_if #(
  parameter int unsigned Y_W = 10
);
  logic           iLineStrobe;
  logic [Y_W-1:0] iLineY;
  logic [1:0]     iCall;
  logic [1:0]     oDone;
  logic [2:0]     oCall;
  logic [2:0]     iDone;
  logic [23:0]    oAddrPage;
  logic           oBusy;
  logic           oOverrun;
  logic           oTimeout;
  logic           iClear;

  // Arbiter side
  modport master (
    input  iLineStrobe, iLineY, iCall, iDone, iClear,
    output oDone, oCall, oAddrPage, oBusy, oOverrun, oTimeout
  );

  // Environment side: display, user port and controller
  modport slave (
    output iLineStrobe, iLineY, iCall, iDone, iClear,
    input  oDone, oCall, oAddrPage, oBusy, oOverrun, oTimeout
  );
endinterface

// File: rtl/sdram_access_arbiter.sv
// Grants the SDRAM controller's page-read / write / read call channels to either
// the queued VGA line refills or the single-word user port, one grant at a time.
module sdram_access_arbiter #(
  parameter int unsigned Y_W         = 10,
  parameter int unsigned LINE_SHIFT  = 9,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input logic                    clk,
  input logic                    rst_n,
  sdram_access_arbiter_if.master bus
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned STV_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RECOVER
  } state_t;

  state_t         state;
  logic [Y_W-1:0] q0;
  logic [Y_W-1:0] q1;
  logic [1:0]     qCount;
  logic [TMR_W-1:0] tmr;
  logic [STV_W-1:0] starve;

  logic       userPend;
  logic       starved;
  logic       grantDone;
  logic       grantExpire;
  logic       grantEnd;
  logic       pagePop;
  logic       pickUser;
  logic       pickPage;
  logic       overrunSet;
  logic [1:0] userPick;

  // Grant completion: matching done bit, or the wait budget runs out
  assign userPend    = |bus.iCall;
  assign starved     = (starve == STV_W'(STARVE_MAX));
  assign grantDone   = (state == GRANT) && (|(bus.iDone & bus.oCall));
  assign grantExpire = (state == GRANT) && !grantDone && (tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign grantEnd    = grantDone || grantExpire;
  assign pagePop     = grantEnd && bus.oCall[2];

  // Priority: starved user, then line refill, then write, then read
  assign pickUser   = (state == IDLE) && userPend && (starved || (qCount == 2'd0));
  assign pickPage   = (state == IDLE) && !pickUser && (qCount != 2'd0);
  assign userPick   = bus.iCall[1] ? 2'b10 : 2'b01;
  assign overrunSet = bus.iLineStrobe && (qCount == 2'd2) && !pagePop;

  // Grant sequencing, call/done outputs and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.oCall     <= '0;
      bus.oDone     <= '0;
      bus.oAddrPage <= '0;
      bus.oBusy     <= 1'b0;
      tmr           <= '0;
      starve        <= '0;
    end else begin
      bus.oDone <= '0;
      unique case (state)
        IDLE: begin
          if (pickUser) begin
            bus.oCall <= {1'b0, userPick};
            bus.oBusy <= 1'b1;
            tmr       <= '0;
            state     <= GRANT;
          end else if (pickPage) begin
            bus.oCall     <= 3'b100;
            bus.oAddrPage <= ADDR_W'(q0) << LINE_SHIFT;
            bus.oBusy     <= 1'b1;
            tmr           <= '0;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (grantEnd) begin
            // A timed-out user grant still releases its requester
            bus.oDone <= bus.oCall[1:0];
            bus.oCall <= '0;
            bus.oBusy <= 1'b0;
            state     <= RECOVER;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!userPend || pickUser) begin
        starve <= '0;
      end else if (pickPage && !starved) begin
        starve <= starve + STV_W'(1);
      end
    end
  end

  // Two-entry line FIFO; a pop in the same cycle frees room for the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0     <= '0;
      q1     <= '0;
      qCount <= '0;
    end else if (pagePop && bus.iLineStrobe) begin
      if (qCount == 2'd2) begin
        q0 <= q1;
        q1 <= bus.iLineY;
      end else begin
        q0 <= bus.iLineY;
      end
    end else if (pagePop) begin
      q0     <= q1;
      qCount <= qCount - 2'd1;
    end else if (bus.iLineStrobe && (qCount != 2'd2)) begin
      if (qCount == 2'd0) begin
        q0 <= bus.iLineY;
      end else begin
        q1 <= bus.iLineY;
      end
      qCount <= qCount + 2'd1;
    end
  end

  // Sticky status flags; a new event outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.oOverrun <= 1'b0;
      bus.oTimeout <= 1'b0;
    end else begin
      bus.oOverrun <= (bus.oOverrun && !bus.iClear) || overrunSet;
      bus.oTimeout <= (bus.oTimeout && !bus.iClear) || grantExpire;
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Bench for sdram_access_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_sdram_access_arbiter;

  localparam int unsigned Y_W         = 10;
  localparam int unsigned LINE_SHIFT  = 9;
  localparam int unsigned STARVE_MAX  = 4;
  localparam int unsigned TIMEOUT_CYC = 1023;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_access_arbiter_if #(.Y_W(Y_W)) bus ();

  sdram_access_arbiter #(
    .Y_W(Y_W), .LINE_SHIFT(LINE_SHIFT), .STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int nTests = 0;
  int nFail  = 0;

  // Reference model: kind 0 none, 1 page, 2 write, 3 read
  int          mQ[$];
  int          mStarve;
  int          mKind;
  int          mAge;
  int          mQuiet;
  logic [23:0] mAddr;
  logic [1:0]  mDone;
  logic        mOv;
  logic        mTo;

  bit         autoCtl;
  bit         autoUser;
  bit         noise;
  int         doneAfter;
  int         timeoutsLeft;
  logic [2:0] grantLog[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] kindBits(input int k);
    case (k)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic modelReset();
    mQ.delete();
    mStarve = 0;
    mKind   = 0;
    mAge    = 0;
    mQuiet  = 0;
    mAddr   = '0;
    mDone   = '0;
    mOv     = 1'b0;
    mTo     = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs now on the bus
  task automatic modelStep();
    logic [1:0] call;
    logic [2:0] done;
    logic [2:0] want;
    bit pop;
    bit ovSet;
    bit toSet;
    call  = bus.iCall;
    done  = bus.iDone;
    pop   = 0;
    ovSet = 0;
    toSet = 0;
    mDone = '0;
    if (mKind != 0) begin
      mAge++;
      want = kindBits(mKind);
      if ((done & want) != 3'b000 || mAge == int'(TIMEOUT_CYC)) begin
        if ((done & want) == 3'b000) toSet = 1;
        if (mKind == 1) pop = 1;
        else mDone = 2'(want);
        mKind  = 0;
        mQuiet = 1;
      end
    end else if (mQuiet > 0) begin
      mQuiet--;
    end else begin
      if (mStarve == int'(STARVE_MAX) && call != 2'b00) begin
        mKind   = call[1] ? 2 : 3;
        mStarve = 0;
      end else if (mQ.size() != 0) begin
        mKind = 1;
        mAddr = 24'(mQ[0] * (1 << LINE_SHIFT));
        if (call != 2'b00 && mStarve < int'(STARVE_MAX)) mStarve++;
      end else if (call[1]) begin
        mKind   = 2;
        mStarve = 0;
      end else if (call[0]) begin
        mKind   = 3;
        mStarve = 0;
      end
      mAge = 0;
    end
    if (call == 2'b00) mStarve = 0;
    if (pop) void'(mQ.pop_front());
    if (bus.iLineStrobe) begin
      if (mQ.size() < 2) mQ.push_back(int'(bus.iLineY));
      else ovSet = 1;
    end
    mOv = (mOv && !bus.iClear) || ovSet;
    mTo = (mTo && !bus.iClear) || toSet;
  endtask

  task automatic compareAll();
    checkVal("oCall",     32'(bus.oCall),     32'(kindBits(mKind)));
    checkVal("oAddrPage", 32'(bus.oAddrPage), 32'(mAddr));
    checkVal("oDone",     32'(bus.oDone),     32'(mDone));
    checkVal("oBusy",     32'(bus.oBusy),     32'(mKind != 0));
    checkVal("oOverrun",  32'(bus.oOverrun),  32'(mOv));
    checkVal("oTimeout",  32'(bus.oTimeout),  32'(mTo));
  endtask

  // Apply current inputs for one cycle, advance model and DUT, compare
  task automatic tick();
    logic [2:0] prevCall;
    if (autoCtl) begin
      bus.iDone = 3'b000;
      if (mKind != 0 && doneAfter != 0 && mAge + 1 == doneAfter) bus.iDone = kindBits(mKind);
      if (noise && $urandom_range(0, 7) == 0)
        bus.iDone = bus.iDone | (3'($urandom_range(0, 7)) & ~kindBits(mKind));
    end
    prevCall = bus.oCall;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
    if (prevCall == 3'b000 && bus.oCall != 3'b000) grantLog.push_back(bus.oCall);
    if (autoUser) bus.iCall = bus.iCall & ~mDone;
    bus.iLineStrobe = 1'b0;
    bus.iClear      = 1'b0;
    bus.iDone       = 3'b000;
  endtask

  task automatic waitGrant(input string tag);
    int n = 0;
    while (bus.oCall == 3'b000 && n < 20) begin
      tick();
      n++;
    end
    checkVal(tag, 32'(bus.oCall != 3'b000), 32'd1);
  endtask

  task automatic strobe(input int y);
    bus.iLineStrobe = 1'b1;
    bus.iLineY      = Y_W'(y);
  endtask

  initial begin
    int held;
    int n;
    rst_n           = 1'b0;
    bus.iLineStrobe = 1'b0;
    bus.iLineY      = '0;
    bus.iCall       = 2'b00;
    bus.iDone       = 3'b000;
    bus.iClear      = 1'b0;
    autoCtl         = 0;
    autoUser        = 0;
    noise           = 0;
    doneAfter       = 2;
    timeoutsLeft    = 3;
    modelReset();
    #1;
    compareAll();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single user write
    bus.iCall = 2'b10;
    tick();
    checkVal("wrGrant", 32'(bus.oCall), 32'h2);
    tick();
    tick();
    bus.iDone = 3'b010;
    tick();
    checkVal("wrDone", 32'(bus.oDone), 32'h2);
    bus.iCall = 2'b00;
    tick();
    checkVal("wrGapBusy", 32'(bus.oBusy), 32'h0);

    // Single line refill, Y=37
    strobe(37);
    waitGrant("pgWait37");
    checkVal("pgAddr37", 32'(bus.oAddrPage), 32'h004A00);
    bus.iDone = 3'b100;
    tick();
    checkVal("pgNoUserDone", 32'(bus.oDone), 32'h0);
    repeat (4) tick();

    // Overrun on third back-to-back strobe
    strobe(1); tick();
    strobe(2); tick();
    strobe(3); tick();
    checkVal("ovrSet", 32'(bus.oOverrun), 32'h1);
    checkVal("ovrAddr1", 32'(bus.oAddrPage), 32'h000200);
    bus.iDone = 3'b100;
    tick();
    waitGrant("ovrWait2");
    checkVal("ovrAddr2", 32'(bus.oAddrPage), 32'h000400);
    bus.iDone = 3'b100;
    tick();
    repeat (5) tick();
    checkVal("ovrQueueEmpty", 32'(bus.oCall), 32'h0);
    bus.iClear = 1'b1;
    tick();
    checkVal("ovrClear", 32'(bus.oOverrun), 32'h0);

    // Starvation guard with a held user read
    autoCtl   = 1;
    autoUser  = 1;
    doneAfter = 2;
    grantLog.delete();
    n = 1;
    strobe(10);
    tick();
    bus.iCall = 2'b01;
    for (int i = 0; i < 150 && grantLog.size() < 6; i++) begin
      if (n < 6 && mQ.size() < 2) begin
        strobe(20 + n);
        n++;
      end
      tick();
    end
    checkVal("starveGrants", 32'(grantLog.size()), 32'd6);
    if (grantLog.size() >= 6)
      checkVal("starveSeq",
               {14'd0, grantLog[0], grantLog[1], grantLog[2], grantLog[3], grantLog[4], grantLog[5]},
               {14'd0, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100});
    repeat (20) tick();

    // Timeout on a page grant, then on a user write
    doneAfter = 0;
    strobe(7);
    waitGrant("toPgWait");
    held = 1;
    for (int i = 0; i < int'(TIMEOUT_CYC) + 10 && bus.oCall != 3'b000; i++) begin
      tick();
      if (bus.oCall != 3'b000) held++;
    end
    checkVal("toPgHeld", 32'(held), 32'(TIMEOUT_CYC));
    checkVal("toPgFlag", 32'(bus.oTimeout), 32'h1);
    repeat (4) tick();
    checkVal("toPgPopped", 32'(bus.oCall), 32'h0);
    bus.iClear = 1'b1;
    tick();
    checkVal("toClear", 32'(bus.oTimeout), 32'h0);
    bus.iCall = 2'b10;
    waitGrant("toWrWait");
    for (int i = 0; i < int'(TIMEOUT_CYC) + 10 && bus.oDone == 2'b00; i++) tick();
    checkVal("toWrDone", 32'(bus.oDone), 32'h2);
    checkVal("toWrFlag", 32'(bus.oTimeout), 32'h1);
    repeat (3) tick();

    // Wrong-bit done ignored, then reset mid-grant
    autoCtl  = 0;
    autoUser = 0;
    bus.iCall = 2'b10;
    waitGrant("rstWait");
    strobe(5);
    tick();
    bus.iDone = 3'b001;
    tick();
    checkVal("wrongBitHeld", 32'(bus.oCall), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    checkVal("rstBusy", 32'(bus.oBusy), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.iCall = 2'b00;
    repeat (6) tick();

    // Randomized traffic
    autoCtl  = 1;
    autoUser = 1;
    noise    = 1;
    for (int i = 0; i < 3000; i++) begin
      if (mKind != 0 && mAge == 0) begin
        doneAfter = $urandom_range(1, 6);
        if (timeoutsLeft > 0 && $urandom_range(0, 60) == 0) begin
          doneAfter = 0;
          timeoutsLeft--;
        end
      end
      if (bus.iCall == 2'b00 && $urandom_range(0, 3) == 0) bus.iCall = 2'($urandom_range(1, 3));
      else if ($urandom_range(0, 150) == 0) bus.iCall = 2'b00;
      if ($urandom_range(0, 4) == 0) strobe(int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 39) == 0) bus.iClear = 1'b1;
      tick();
    end

    noise     = 0;
    autoUser  = 0;
    bus.iCall = 2'b00;
    doneAfter = 1;
    repeat (int'(TIMEOUT_CYC) + 20) begin
      if (mKind == 0 && mQ.size() == 0 && mQuiet == 0) break;
      tick();
    end
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
